ex: RTL and testbench
=====================

Name: ex

Overview:
- Third pipeline stage (execute) of the ARC MIPS processor, directly upstream of the memory-access stage.
- Performs ALU operations and computes the branch target address.
- Holds the EX/MEM pipeline register, whose outputs feed the memory stage's control, Zero, ALU-result and destination-address inputs.
- Adds an iterative 32-cycle unsigned multiplier (MULTU) with HI/LO registers; it stalls the front end while busy.

Parameters:
- MUL_CYCLES, 32, number of shift-add iterations. Fixed at 32 for a 32-bit datapath.

Ports:
- i_clk  input  1  clock. All state updates on the rising edge.
- i_rst_n  input  1  reset. Synchronous, active-low.
- i_con_ex_alusrc  input  1  1 selects i_data_SignExt as ALU operand B; 0 selects i_data_Rt.
- i_con_ex_aluop  input  2  00 add, 01 sub, 10 decode funct, 11 reserved (treated as add).
- i_con_ex_regdst  input  1  1 selects i_addr_Rd as destination; 0 selects i_addr_Rt.
- i_con_mem_branch, i_con_mem_memread, i_con_mem_memwrite, i_con_wb_memtoreg, i_con_wb_regwrite  input  1 each  pass-through control.
- i_data_PC4  input  32  PC+4 of the instruction.
- i_data_Rs, i_data_Rt  input  32  register operands.
- i_data_SignExt  input  32  sign-extended immediate; bits [5:0] are funct.
- i_addr_Rt, i_addr_Rd  input  5  destination candidates.
- o_con_mem_branch, o_con_mem_memread, o_con_mem_memwrite, o_con_wb_memtoreg, o_con_wb_regwrite  output  1 each  registered control.
- o_con_Zero  output  1  registered; 1 when the ALU result equals 0.
- o_data_ALU_Rst  output  32  registered ALU result.
- o_data_Rt  output  32  registered store data.
- o_addr_MuxRst  output  5  registered destination register.
- o_data_BranchAddr  output  32  registered value of PC4 + (SignExt << 2), truncated mod 2^32.
- o_stall  output  1  combinational; 1 means upstream must hold the PC and the ID/EX register.

Behaviour:
- Reset (i_rst_n = 0 at the edge): all outputs and the EX/MEM register go to 0; HI = LO = 0; FSM goes to IDLE; the multiplier counter goes to 0. Reset wins over every other event, including mid-multiply; a partial product is discarded.
- ALU latency: 1 cycle. Inputs are sampled at edge N and results are visible after edge N.
- Funct decode when aluop = 10:
  - 100000 add, 100010 sub, 100100 and, 100101 or, 100111 nor.
  - 101010 slt (signed, result 0 or 1).
  - 010000 mfhi (result = HI), 010010 mflo (result = LO).
  - 011001 multu.
  - Any other funct: result 0.
- Arithmetic is 32-bit wraparound with no overflow trap.
- o_con_Zero = (registered result == 0), computed from the same result that is registered.
- Multiplier FSM: IDLE, BUSY, DONE.
  - IDLE, MULTU not present: normal operation; o_stall = 0.
  - IDLE, MULTU present (aluop = 10, funct = 011001):
    - o_stall = 1 in the same cycle.
    - Next state BUSY; latch multiplicand = Rs and multiplier = Rt; clear the 64-bit accumulator; counter = 0.
    - The EX/MEM register loads a bubble (all control 0, data 0).
  - BUSY: o_stall = 1.
    - Each cycle performs one shift-add step and increments the counter.
    - The EX/MEM register loads a bubble.
    - After step MUL_CYCLES (counter = 31 at the edge): HI = acc[63:32], LO = acc[31:0]; next state DONE.
  - DONE: o_stall = 0. The EX/MEM register captures MULTU with regwrite and memwrite forced to 0. Next state IDLE.
- MULTU timing: the stall is 33 cycles (1 accept + 32 BUSY). The MULTU leaves EX on the 34th cycle.
- An mfhi or mflo immediately following a MULTU reads the new HI/LO.
- Upstream must keep the ID/EX inputs stable while o_stall = 1. This block does not re-sample them during BUSY.
- Back-to-back MULTU: the second starts from IDLE on the cycle after DONE.

Optional Feature:
- Macro: EX_DIVU_EN.
- Defined:
  - Adds DIVU (funct 011011): restoring unsigned division over the same FSM (BUSY for 32 steps).
  - LO = quotient, HI = remainder.
  - Divide by zero: LO = 32'hFFFF_FFFF, HI = Rs.
  - Stall timing is identical to MULTU.
- Not defined: funct 011011 decodes as an unknown funct (result 0, no stall, HI/LO unchanged).

Test Plan:
- add: Rs = 5, Rt = 7, aluop = 10, funct = 100000, regdst = 1, Rd = 3 -> next cycle ALU_Rst = 12, Zero = 0, MuxRst = 3, control passed through.
- beq path: aluop = 01, Rs = Rt = 0x1234, PC4 = 0x100, SignExt = 4, branch = 1 -> Zero = 1, BranchAddr = 0x110, o_con_mem_branch = 1.
- multu then mflo/mfhi: Rs = 0xFFFFFFFF, Rt = 2 -> o_stall high exactly 33 cycles, then mflo gives 0xFFFFFFFE and mfhi gives 0x00000001; bubbles (regwrite 0) appear on the outputs during the stall.
- Reset mid-multiply: assert i_rst_n = 0 at BUSY step 10 -> next edge o_stall = 0, all outputs 0, mfhi afterwards returns 0.
- slt signed: Rs = 0xFFFFFFFF, Rt = 1 -> ALU_Rst = 1; unknown funct 111111 -> ALU_Rst = 0, Zero = 1.
- EX_DIVU_EN: Rs = 100, Rt = 7 -> LO = 14, HI = 2; Rt = 0 -> LO = 0xFFFFFFFF, HI = 100; without the macro -> no stall, HI/LO unchanged.

Source files
------------

// File: rtl/ex.sv
// rtl/ex.sv - ARC MIPS execute stage: ALU, branch target, EX/MEM register, iterative MULTU.
// Optional DIVU (funct 011011) on the same sequencer when EX_DIVU_EN is defined.
module ex #(
  parameter int MUL_CYCLES = 32
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_con_ex_alusrc,
  input  logic [1:0]  i_con_ex_aluop,
  input  logic        i_con_ex_regdst,
  input  logic        i_con_mem_branch,
  input  logic        i_con_mem_memread,
  input  logic        i_con_mem_memwrite,
  input  logic        i_con_wb_memtoreg,
  input  logic        i_con_wb_regwrite,
  input  logic [31:0] i_data_PC4,
  input  logic [31:0] i_data_Rs,
  input  logic [31:0] i_data_Rt,
  input  logic [31:0] i_data_SignExt,
  input  logic [4:0]  i_addr_Rt,
  input  logic [4:0]  i_addr_Rd,
  output logic        o_con_mem_branch,
  output logic        o_con_mem_memread,
  output logic        o_con_mem_memwrite,
  output logic        o_con_wb_memtoreg,
  output logic        o_con_wb_regwrite,
  output logic        o_con_Zero,
  output logic [31:0] o_data_ALU_Rst,
  output logic [31:0] o_data_Rt,
  output logic [4:0]  o_addr_MuxRst,
  output logic [31:0] o_data_BranchAddr,
  output logic        o_stall
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam logic [4:0] LAST_STEP = 5'(MUL_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;
  logic        w_stall;
  logic        w_bubble;

  logic [31:0] r_hi, r_lo;
  logic [31:0] r_opa, r_opb;
  logic [63:0] r_acc;
  logic [4:0]  r_cnt;

  logic        r_branch, r_memread, r_memwrite, r_memtoreg, r_regwrite, r_zero;
  logic [31:0] r_alu, r_rt, r_baddr;
  logic [4:0]  r_dst;

  logic [5:0]  w_funct;
  logic [31:0] w_op_b;
  logic [31:0] w_alu;
  logic [31:0] w_baddr;
  logic        w_is_mul;
  logic        w_is_div;
  logic        w_long;
  logic [32:0] w_mul_sum;
  logic [63:0] w_mul_acc;
  logic [63:0] w_step_acc;

  assign w_funct  = i_data_SignExt[5:0];
  assign w_op_b   = i_con_ex_alusrc ? i_data_SignExt : i_data_Rt;
  assign w_baddr  = i_data_PC4 + {i_data_SignExt[29:0], 2'b00};
  assign w_is_mul = (i_con_ex_aluop == 2'b10) && (w_funct == 6'b011001);

  // Shift-add: accumulate into the upper half, shift the product down one bit per step.
  assign w_mul_sum = {1'b0, r_acc[63:32]} + {1'b0, (r_opb[0] ? r_opa : 32'h0)};
  assign w_mul_acc = {w_mul_sum, r_acc[31:1]};

`ifdef EX_DIVU_EN
  logic        r_div;
  logic [32:0] w_div_trial;
  logic [63:0] w_div_acc;

  assign w_is_div = (i_con_ex_aluop == 2'b10) && (w_funct == 6'b011011);
  // Restoring step: remainder in acc[63:32], dividend shifts out of / quotient shifts into acc[31:0].
  assign w_div_trial = r_acc[63:31] - {1'b0, r_opb};
  assign w_div_acc   = w_div_trial[32] ? {r_acc[62:0], 1'b0}
                                       : {w_div_trial[31:0], r_acc[30:0], 1'b1};
  assign w_step_acc  = r_div ? w_div_acc : w_mul_acc;
`else
  assign w_is_div   = 1'b0;
  assign w_step_acc = w_mul_acc;
`endif

  assign w_long = w_is_mul | w_is_div;

  always_comb begin
    w_alu = 32'h0;
    case (i_con_ex_aluop)
      2'b01: w_alu = i_data_Rs - w_op_b;
      2'b10: begin
        case (w_funct)
          6'b100000: w_alu = i_data_Rs + w_op_b;
          6'b100010: w_alu = i_data_Rs - w_op_b;
          6'b100100: w_alu = i_data_Rs & w_op_b;
          6'b100101: w_alu = i_data_Rs | w_op_b;
          6'b100111: w_alu = ~(i_data_Rs | w_op_b);
          6'b101010: w_alu = {31'h0, ($signed(i_data_Rs) < $signed(w_op_b))};
          6'b010000: w_alu = r_hi;
          6'b010010: w_alu = r_lo;
          default:   w_alu = 32'h0;
        endcase
      end
      default: w_alu = i_data_Rs + w_op_b;
    endcase
  end

  always_comb begin
    w_next   = r_state;
    w_stall  = 1'b0;
    w_bubble = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_long) begin
          w_next   = S_BUSY;
          w_stall  = 1'b1;
          w_bubble = 1'b1;
        end
      end
      S_BUSY: begin
        w_stall  = 1'b1;
        w_bubble = 1'b1;
        if (r_cnt == LAST_STEP) begin
          w_next = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign o_stall = w_stall;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_hi       <= 32'h0;
      r_lo       <= 32'h0;
      r_opa      <= 32'h0;
      r_opb      <= 32'h0;
      r_acc      <= 64'h0;
      r_cnt      <= 5'd0;
`ifdef EX_DIVU_EN
      r_div      <= 1'b0;
`endif
      r_branch   <= 1'b0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
      r_memtoreg <= 1'b0;
      r_regwrite <= 1'b0;
      r_zero     <= 1'b0;
      r_alu      <= 32'h0;
      r_rt       <= 32'h0;
      r_dst      <= 5'd0;
      r_baddr    <= 32'h0;
    end else begin
      r_state <= w_next;

      if (r_state == S_IDLE && w_long) begin
        r_opa <= i_data_Rs;
        r_opb <= i_data_Rt;
        r_cnt <= 5'd0;
`ifdef EX_DIVU_EN
        r_div <= w_is_div;
        r_acc <= w_is_div ? {32'h0, i_data_Rs} : 64'h0;
`else
        r_acc <= 64'h0;
`endif
      end else if (r_state == S_BUSY) begin
        r_acc <= w_step_acc;
        r_opb <= r_opb >> 1;
`ifdef EX_DIVU_EN
        if (r_div) begin
          r_opb <= r_opb;
        end
`endif
        r_cnt <= r_cnt + 5'd1;
        if (r_cnt == LAST_STEP) begin
          r_hi <= w_step_acc[63:32];
          r_lo <= w_step_acc[31:0];
        end
      end

      if (w_bubble) begin
        r_branch   <= 1'b0;
        r_memread  <= 1'b0;
        r_memwrite <= 1'b0;
        r_memtoreg <= 1'b0;
        r_regwrite <= 1'b0;
        r_zero     <= 1'b0;
        r_alu      <= 32'h0;
        r_rt       <= 32'h0;
        r_dst      <= 5'd0;
        r_baddr    <= 32'h0;
      end else begin
        // The retiring multi-cycle op must not write the register file or memory.
        r_branch   <= i_con_mem_branch;
        r_memread  <= i_con_mem_memread;
        r_memwrite <= i_con_mem_memwrite && (r_state != S_DONE);
        r_memtoreg <= i_con_wb_memtoreg;
        r_regwrite <= i_con_wb_regwrite && (r_state != S_DONE);
        r_zero     <= (w_alu == 32'h0);
        r_alu      <= w_alu;
        r_rt       <= i_data_Rt;
        r_dst      <= i_con_ex_regdst ? i_addr_Rd : i_addr_Rt;
        r_baddr    <= w_baddr;
      end
    end
  end

  assign o_con_mem_branch   = r_branch;
  assign o_con_mem_memread  = r_memread;
  assign o_con_mem_memwrite = r_memwrite;
  assign o_con_wb_memtoreg  = r_memtoreg;
  assign o_con_wb_regwrite  = r_regwrite;
  assign o_con_Zero         = r_zero;
  assign o_data_ALU_Rst     = r_alu;
  assign o_data_Rt          = r_rt;
  assign o_addr_MuxRst      = r_dst;
  assign o_data_BranchAddr  = r_baddr;

endmodule

// File: tb/tb_ex.sv
// tb/tb_ex.sv - scoreboard bench for the execute stage (directed vectors, EX_DIVU_EN aware).
module tb_ex;

  localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25;
  localparam logic [5:0] F_NOR = 6'h27, F_SLT = 6'h2A, F_MFHI = 6'h10, F_MFLO = 6'h12;
  localparam logic [5:0] F_MULTU = 6'h19, F_DIVU = 6'h1B;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alusrc, regdst;
  logic [1:0]  aluop;
  logic [4:0]  ctrl;
  logic [31:0] pc4, rs, rt, se;
  logic [4:0]  art, ard;

  logic        o_branch, o_memread, o_memwrite, o_memtoreg, o_regwrite, o_zero, o_stall;
  logic [31:0] o_alu, o_rt, o_baddr;
  logic [4:0]  o_dst;

  ex dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_con_ex_alusrc(alusrc), .i_con_ex_aluop(aluop), .i_con_ex_regdst(regdst),
    .i_con_mem_branch(ctrl[4]), .i_con_mem_memread(ctrl[3]), .i_con_mem_memwrite(ctrl[2]),
    .i_con_wb_memtoreg(ctrl[1]), .i_con_wb_regwrite(ctrl[0]),
    .i_data_PC4(pc4), .i_data_Rs(rs), .i_data_Rt(rt), .i_data_SignExt(se),
    .i_addr_Rt(art), .i_addr_Rd(ard),
    .o_con_mem_branch(o_branch), .o_con_mem_memread(o_memread), .o_con_mem_memwrite(o_memwrite),
    .o_con_wb_memtoreg(o_memtoreg), .o_con_wb_regwrite(o_regwrite), .o_con_Zero(o_zero),
    .o_data_ALU_Rst(o_alu), .o_data_Rt(o_rt), .o_addr_MuxRst(o_dst),
    .o_data_BranchAddr(o_baddr), .o_stall(o_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    string       name;
    logic [31:0] alu;
    logic        zero;
    logic [4:0]  ctl;
    logic [4:0]  dst;
    logic [31:0] rt;
    logic [31:0] ba;
    logic        chk_stall;
    logic        stall;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] got;
    logic [31:0] want;
  } scal_t;

  exp_t  sb[$];
  scal_t sq[$];
  int    cyc = 0;
  int    n_chk = 0;
  int    n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops every expectation due at this cycle and compares against the registered outputs.
  always @(negedge clk) begin
    exp_t  e;
    scal_t s;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      n_chk++;
      if (e.cyc != cyc ||
          {o_alu, o_zero, o_branch, o_memread, o_memwrite, o_memtoreg, o_regwrite, o_dst, o_rt, o_baddr} !=
          {e.alu, e.zero, e.ctl, e.dst, e.rt, e.ba}) begin
        n_err++;
        $display("FAIL %s @%0d: got alu=%h zero=%b ctl=%b dst=%0d rt=%h ba=%h, expected alu=%h zero=%b ctl=%b dst=%0d rt=%h ba=%h",
                 e.name, cyc, o_alu, o_zero, {o_branch, o_memread, o_memwrite, o_memtoreg, o_regwrite},
                 o_dst, o_rt, o_baddr, e.alu, e.zero, e.ctl, e.dst, e.rt, e.ba);
      end
      if (e.chk_stall) begin
        n_chk++;
        if (o_stall !== e.stall) begin
          n_err++;
          $display("FAIL %s_stall @%0d: got %b expected %b", e.name, cyc, o_stall, e.stall);
        end
      end
    end
    while (sq.size() > 0) begin
      s = sq.pop_front();
      n_chk++;
      if (s.got !== s.want) begin
        n_err++;
        $display("FAIL %s: got %0d (%h) expected %0d (%h)", s.name, s.got, s.got, s.want, s.want);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic post(input string nm, input logic [31:0] got, input logic [31:0] want);
    scal_t s;
    s.name = nm; s.got = got; s.want = want;
    sq.push_back(s);
  endtask

  task automatic push(input string nm, input logic [31:0] a, input logic z, input logic [4:0] c,
                      input logic [4:0] d, input logic [31:0] r, input logic [31:0] b,
                      input logic cs, input logic st);
    exp_t e;
    e.cyc = cyc + 1; e.name = nm; e.alu = a; e.zero = z; e.ctl = c; e.dst = d;
    e.rt = r; e.ba = b; e.chk_stall = cs; e.stall = st;
    sb.push_back(e);
  endtask

  task automatic drive(input logic [1:0] op, input logic src, input logic dsel, input logic [4:0] c,
                       input logic [31:0] p, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic [4:0] t, input logic [4:0] d);
    aluop = op; alusrc = src; regdst = dsel; ctrl = c; pc4 = p;
    rs = a; rt = b; se = imm; art = t; ard = d;
  endtask

  // Expected pass-through fields follow from the stimulus; the ALU value is hand-computed.
  task automatic issue(input string nm, input logic [1:0] op, input logic src, input logic dsel,
                       input logic [4:0] c, input logic [31:0] p, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] imm, input logic [4:0] t,
                       input logic [4:0] d, input logic [31:0] exp_alu);
    drive(op, src, dsel, c, p, a, b, imm, t, d);
    push(nm, exp_alu, exp_alu == 32'h0, c, dsel ? d : t, b, p + (imm << 2), 1'b0, 1'b0);
    step();
  endtask

  task automatic rtype(input string nm, input logic [5:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_alu);
    issue(nm, 2'b10, 1'b0, 1'b1, 5'b00001, 32'h4, a, b, {26'h0, f}, 5'd2, 5'd3, exp_alu);
  endtask

  // Multi-cycle op: counts stall cycles, expects bubbles each edge, then the retire with writes masked.
  task automatic long_op(input string nm, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    int n;
    drive(2'b10, 1'b0, 1'b1, 5'b00101, 32'h200, a, b, {26'h0, f}, 5'd2, 5'd4);
    #1;
    n = 0;
    while (o_stall && n < 100) begin
      push({nm, "_bubble"}, 32'h0, 1'b0, 5'b0, 5'd0, 32'h0, 32'h0, 1'b1, n < 32);
      step();
      n++;
    end
    post({nm, "_stall_cycles"}, n, 33);
    push({nm, "_retire"}, 32'h0, 1'b1, 5'b00000, 5'd4, b, 32'h200 + ({26'h0, f} << 2), 1'b0, 1'b0);
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    drive(2'b10, 1'b0, 1'b1, 5'b11111, 32'h4, 32'd5, 32'd7, {26'h0, F_ADD}, 5'd2, 5'd3);
    push("reset0", 32'h0, 1'b0, 5'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    push("reset1", 32'h0, 1'b0, 5'b0, 5'd0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    rst_n = 1'b1;

    rtype("add",      F_ADD, 32'd5,        32'd7,        32'd12);
    issue("beq", 2'b01, 1'b0, 1'b0, 5'b10000, 32'h100, 32'h1234, 32'h1234, 32'd4, 5'd5, 5'd6, 32'h0);
    rtype("sub",      F_SUB, 32'd10,       32'd3,        32'd7);
    rtype("sub_wrap", F_SUB, 32'd0,        32'd1,        32'hFFFF_FFFF);
    rtype("add_wrap", F_ADD, 32'hFFFF_FFFF, 32'd1,       32'h0);
    rtype("and",      F_AND, 32'hF0F0,     32'hFF00,     32'hF000);
    rtype("or",       F_OR,  32'hF0F0,     32'hFF00,     32'hFFF0);
    rtype("nor",      F_NOR, 32'h0,        32'h0,        32'hFFFF_FFFF);
    rtype("slt_neg",  F_SLT, 32'hFFFF_FFFF, 32'd1,       32'd1);
    rtype("slt_pos",  F_SLT, 32'd1,        32'hFFFF_FFFF, 32'd0);
    rtype("unknown",  6'h3F, 32'd9,        32'd9,        32'h0);
    issue("lw",  2'b00, 1'b1, 1'b0, 5'b01011, 32'h40, 32'h1000, 32'hAAAA, 32'hFFFF_FFFC, 5'd7, 5'd9, 32'hFFC);
    issue("sw",  2'b00, 1'b1, 1'b0, 5'b00100, 32'h80, 32'h20, 32'h55, 32'd8, 5'd1, 5'd9, 32'h28);
    issue("op11", 2'b11, 1'b0, 1'b1, 5'b00001, 32'h8, 32'd3, 32'd4, 32'd0, 5'd1, 5'd2, 32'd7);

    long_op("multu", F_MULTU, 32'hFFFF_FFFF, 32'd2);
    rtype("mflo", F_MFLO, 32'h0, 32'h0, 32'hFFFF_FFFE);
    rtype("mfhi", F_MFHI, 32'h0, 32'h0, 32'h1);

`ifdef EX_DIVU_EN
    long_op("divu", F_DIVU, 32'd100, 32'd7);
    rtype("divu_lo", F_MFLO, 32'h0, 32'h0, 32'd14);
    rtype("divu_hi", F_MFHI, 32'h0, 32'h0, 32'd2);
    long_op("divu0", F_DIVU, 32'd100, 32'd0);
    rtype("divu0_lo", F_MFLO, 32'h0, 32'h0, 32'hFFFF_FFFF);
    rtype("divu0_hi", F_MFHI, 32'h0, 32'h0, 32'd100);
`else
    drive(2'b10, 1'b0, 1'b1, 5'b00001, 32'h4, 32'd100, 32'd7, {26'h0, F_DIVU}, 5'd2, 5'd3);
    #1;
    post("divu_off_stall", {31'h0, o_stall}, 32'h0);
    push("divu_off", 32'h0, 1'b1, 5'b00001, 5'd3, 32'd7, 32'h4 + ({26'h0, F_DIVU} << 2), 1'b0, 1'b0);
    step();
    rtype("divu_off_lo", F_MFLO, 32'h0, 32'h0, 32'hFFFF_FFFE);
    rtype("divu_off_hi", F_MFHI, 32'h0, 32'h0, 32'h1);
`endif

    // Second multiply aborted by reset part-way through BUSY.
    drive(2'b10, 1'b0, 1'b1, 5'b00001, 32'h0, 32'd3, 32'd5, {26'h0, F_MULTU}, 5'd2, 5'd3);
    repeat (11) step();
    rst_n = 1'b0;
    drive(2'b10, 1'b0, 1'b1, 5'b00001, 32'h4, 32'h0, 32'h0, {26'h0, F_MFHI}, 5'd2, 5'd3);
    push("mid_reset", 32'h0, 1'b0, 5'b0, 5'd0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    rst_n = 1'b1;
    rtype("mfhi_after_rst", F_MFHI, 32'h0, 32'h0, 32'h0);
    rtype("mflo_after_rst", F_MFLO, 32'h0, 32'h0, 32'h0);

    step();
    post("sb_drained", sb.size(), 0);
    step();
    step();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
